// File: rtl/spi_slave.sv
// SPI slave front end: deserialises 10-bit command frames from MOSI and shifts
// a RAM read byte back on MISO after a read-data command.
module spi_slave #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid
);

  localparam int FRAME_W = DATA_WIDTH + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int TXC_W   = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    bit_cnt;
  logic [FRAME_W-1:0]  frame_sh;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [TXC_W-1:0]    tx_left;
  logic                rd_addr_seen;
  logic                tx_loaded;
  logic                rx_done;
  logic                in_frame;
  logic                frame_done;
  logic                shift_in;
  logic                tx_load;
  logic                tx_shift;

  always_comb begin
    state_nxt  = state;
    in_frame   = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    shift_in   = !SS_n && ((state == CHK_CMD) ||
                           (in_frame && (bit_cnt < CNT_W'(FRAME_W))));
    frame_done = in_frame && !SS_n && (bit_cnt == CNT_W'(FRAME_W - 1));
    // A stale tx_valid level is locked out by tx_loaded until the frame ends.
    tx_load    = (state == READ_DATA) && !SS_n && rx_done && !tx_loaded && tx_valid;
    tx_shift   = (state == READ_DATA) && !SS_n && tx_loaded && (tx_left != '0);
    case (state)
      IDLE: begin
        if (!SS_n) state_nxt = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n)              state_nxt = IDLE;
        else if (!MOSI)        state_nxt = WRITE;
        else if (rd_addr_seen) state_nxt = READ_DATA;
        else                   state_nxt = READ_ADD;
      end
      default: begin
        if (SS_n) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_done      <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_loaded    <= 1'b0;
      tx_left      <= '0;
      MISO         <= 1'b0;
    end else begin
      state    <= state_nxt;
      rx_valid <= frame_done;
      if (frame_done) rx_data <= {frame_sh[FRAME_W-2:0], MOSI};

      if (SS_n || (state == IDLE)) begin
        bit_cnt <= '0;
        rx_done <= 1'b0;
      end else if (state == CHK_CMD) begin
        bit_cnt <= CNT_W'(1);
      end else if (shift_in) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (frame_done) rx_done <= 1'b1;
      end

      if (frame_done && (state == READ_ADD))
        rd_addr_seen <= 1'b1;
      else if (tx_shift && (tx_left == TXC_W'(1)))
        rd_addr_seen <= 1'b0;

      // MISO return path: MSB straight from tx_data, remaining bits from tx_sh.
      if (SS_n || (state != READ_DATA)) begin
        MISO      <= 1'b0;
        tx_loaded <= 1'b0;
        tx_left   <= '0;
      end else if (tx_load) begin
        MISO      <= tx_data[DATA_WIDTH-1];
        tx_loaded <= 1'b1;
        tx_left   <= TXC_W'(DATA_WIDTH - 1);
      end else if (tx_shift) begin
        MISO    <= tx_sh[DATA_WIDTH-1];
        tx_left <= tx_left - TXC_W'(1);
      end else begin
        MISO <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (shift_in) frame_sh <= {frame_sh[FRAME_W-2:0], MOSI};
    if (tx_load)
      tx_sh <= {tx_data[DATA_WIDTH-2:0], 1'b0};
    else if (tx_shift)
      tx_sh <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave: write, read, abort, reset, stale tx_valid
// and overlong frames, with hand-computed expected values.
module tb_spi_slave;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       ram_tv;
  logic       tv_force;

  int checks;
  int errors;

  logic       rv_log   [0:31];
  logic       miso_log [0:31];
  logic [9:0] rxd_log  [0:31];
  logic [2:0] st_log   [0:31];

  spi_slave #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: raises read-data valid one edge after a read-data command
  // completes and holds it until the frame ends.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   ram_tv <= 1'b0;
    else if (SS_n)                                ram_tv <= 1'b0;
    else if (rx_valid && (rx_data[9:8] == 2'b11)) ram_tv <= 1'b1;
  end

  assign tx_valid = ram_tv | tv_force;

  // Log index j holds the outputs just after edge k+j, where edge k is the
  // first edge to sample SS_n low. Bits are taken MSB first from bits[13].
  task automatic run_frame(input logic [13:0] bits, input int nbits, input int ncyc);
    for (int c = 0; c <= ncyc; c++) begin
      @(negedge clk);
      if (c > 0) begin
        rv_log[c-1]   = rx_valid;
        miso_log[c-1] = MISO;
        rxd_log[c-1]  = rx_data;
        st_log[c-1]   = dut.state;
      end
      if (c == ncyc) begin
        SS_n = 1'b1;
        MOSI = 1'b0;
      end else begin
        SS_n = 1'b0;
        MOSI = (c >= 1 && c <= nbits) ? bits[14-c] : 1'b0;
      end
    end
    @(negedge clk);
    rv_log[ncyc]   = rx_valid;
    miso_log[ncyc] = MISO;
    rxd_log[ncyc]  = rx_data;
    st_log[ncyc]   = dut.state;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tv_force = 1'b0;
    #12;
    checks++;
    if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", MISO); end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++;
    if (rx_data !== 10'h000) begin errors++; $display("FAIL reset_rx_data: got %h expected 000", rx_data); end
    checks++;
    if (dut.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dut.state); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_write_frame(input logic [9:0] f, input string nm);
    int cnt;
    run_frame({f, 4'b0000}, 10, 12);
    cnt = 0;
    for (int j = 0; j <= 12; j++) if (rv_log[j] === 1'b1) cnt++;
    checks++;
    if (rv_log[10] !== 1'b1 || cnt != 1) begin
      errors++; $display("FAIL %s_rx_valid: at_k10=%b pulses=%0d expected 1 and 1", nm, rv_log[10], cnt);
    end
    checks++;
    if (rv_log[9] !== 1'b0 || rv_log[11] !== 1'b0) begin
      errors++; $display("FAIL %s_rx_valid_width: k9=%b k11=%b expected 0 0", nm, rv_log[9], rv_log[11]);
    end
    checks++;
    if (rxd_log[10] !== f) begin
      errors++; $display("FAIL %s_rx_data: got %h expected %h", nm, rxd_log[10], f);
    end
    checks++;
    if (st_log[1] !== 3'd2) begin
      errors++; $display("FAIL %s_state: got %0d expected 2", nm, st_log[1]);
    end
  endtask

  task automatic test_write;
    check_write_frame(10'h0A5, "write_addr");
    check_write_frame(10'h13C, "write_data");
    checks++;
    if (rx_data !== 10'h13C) begin errors++; $display("FAIL write_hold: got %h expected 13c", rx_data); end
  endtask

  task automatic test_reset_mid_frame;
    @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); MOSI = i[0];
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (MISO !== 1'b0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: miso=%b rx_valid=%b expected 0 0", MISO, rx_valid);
    end
    checks++;
    if (rx_data !== 10'h000) begin errors++; $display("FAIL midrst_rx_data: got %h expected 000", rx_data); end
    checks++;
    if (dut.state !== 3'd0) begin errors++; $display("FAIL midrst_state: got %0d expected 0", dut.state); end
    @(negedge clk);
    rst_n = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
    @(negedge clk);
    run_frame({10'h055, 4'b0000}, 10, 12);
    checks++;
    if (st_log[0] !== 3'd1 || st_log[1] !== 3'd2) begin
      errors++; $display("FAIL midrst_restart_state: k0=%0d k1=%0d expected 1 2", st_log[0], st_log[1]);
    end
    checks++;
    if (rv_log[10] !== 1'b1 || rxd_log[10] !== 10'h055) begin
      errors++; $display("FAIL midrst_restart_frame: rv=%b data=%h expected 1 055", rv_log[10], rxd_log[10]);
    end
  endtask

  task automatic test_read;
    logic [7:0] byte_v;
    logic       exp_bit;
    int         bad;
    run_frame({10'h25A, 4'b0000}, 10, 12);
    checks++;
    if (st_log[1] !== 3'd3) begin errors++; $display("FAIL read_add_state: got %0d expected 3", st_log[1]); end
    checks++;
    if (rv_log[10] !== 1'b1 || rxd_log[10] !== 10'h25A) begin
      errors++; $display("FAIL read_add_frame: rv=%b data=%h expected 1 25a", rv_log[10], rxd_log[10]);
    end
    checks++;
    if (dut.rd_addr_seen !== 1'b1) begin errors++; $display("FAIL read_add_seen: got %b expected 1", dut.rd_addr_seen); end

    tx_data = 8'hC3;
    byte_v  = 8'hC3;
    run_frame({10'h300, 4'b0000}, 10, 24);
    checks++;
    if (st_log[1] !== 3'd4) begin errors++; $display("FAIL read_data_state: got %0d expected 4", st_log[1]); end
    checks++;
    if (rv_log[10] !== 1'b1 || rxd_log[10] !== 10'h300) begin
      errors++; $display("FAIL read_data_frame: rv=%b data=%h expected 1 300", rv_log[10], rxd_log[10]);
    end
    for (int j = 0; j <= 23; j++) begin
      exp_bit = 1'b0;
      if (j >= 12 && j <= 19) exp_bit = byte_v[19-j];
      checks++;
      if (miso_log[j] !== exp_bit) begin
        errors++; $display("FAIL read_miso_k%0d: got %b expected %b", j, miso_log[j], exp_bit);
      end
    end
    checks++;
    if (dut.rd_addr_seen !== 1'b0) begin errors++; $display("FAIL read_seen_clear: got %b expected 0", dut.rd_addr_seen); end
    bad = 0;
    for (int j = 0; j <= 24; j++) if (rv_log[j] === 1'b1 && j != 10) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL read_extra_rx_valid: got %0d expected 0", bad); end
  endtask

  task automatic test_abort;
    int cnt;
    run_frame({10'h2FF, 4'b0000}, 5, 6);
    checks++;
    if (st_log[1] !== 3'd3) begin errors++; $display("FAIL abort_enter_state: got %0d expected 3", st_log[1]); end
    cnt = 0;
    for (int j = 0; j <= 6; j++) if (rv_log[j] === 1'b1) cnt++;
    checks++;
    if (cnt != 0) begin errors++; $display("FAIL abort_rx_valid: got %0d pulses expected 0", cnt); end
    checks++;
    if (st_log[5] !== 3'd3 || st_log[6] !== 3'd0) begin
      errors++; $display("FAIL abort_idle: k5=%0d k6=%0d expected 3 0", st_log[5], st_log[6]);
    end
    checks++;
    if (dut.rd_addr_seen !== 1'b0) begin errors++; $display("FAIL abort_seen: got %b expected 0", dut.rd_addr_seen); end
    checks++;
    if (rxd_log[6] !== 10'h300) begin errors++; $display("FAIL abort_rx_hold: got %h expected 300", rxd_log[6]); end
  endtask

  task automatic test_stale_tx_valid;
    int ones;
    int cnt;
    tx_data  = 8'hFF;
    tv_force = 1'b1;
    run_frame({10'h0FF, 4'b0000}, 10, 22);
    ones = 0;
    cnt  = 0;
    for (int j = 0; j <= 22; j++) begin
      if (miso_log[j] !== 1'b0) ones++;
      if (rv_log[j] === 1'b1) cnt++;
    end
    checks++;
    if (ones != 0) begin errors++; $display("FAIL stale_miso: got %0d nonzero bits expected 0", ones); end
    checks++;
    if (cnt != 1 || rxd_log[10] !== 10'h0FF) begin
      errors++; $display("FAIL stale_frame: pulses=%0d data=%h expected 1 0ff", cnt, rxd_log[10]);
    end
    tv_force = 1'b0;
  endtask

  task automatic test_overlong;
    int cnt;
    run_frame(14'b00_1111_0000_1011, 14, 16);
    cnt = 0;
    for (int j = 0; j <= 16; j++) if (rv_log[j] === 1'b1) cnt++;
    checks++;
    if (cnt != 1 || rv_log[10] !== 1'b1) begin
      errors++; $display("FAIL overlong_rx_valid: pulses=%0d at_k10=%b expected 1 1", cnt, rv_log[10]);
    end
    checks++;
    if (rxd_log[16] !== 10'h0F0) begin errors++; $display("FAIL overlong_rx_data: got %h expected 0f0", rxd_log[16]); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_write;
    test_reset_mid_frame;
    test_read;
    test_abort;
    test_stale_tx_valid;
    test_overlong;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
